counter_updown_mod: RTL

Parametrised synchronous up/down modulo counter. It is the successor to the team's ripple JK counter: fully synchronous, direction selectable at run time, programmable limit, and selectable wrap or saturate mode. It adds a load port and a registered terminal-count pulse. It is used for loop counters, timeout timers and pointer generation throughout the core.

---
 rtl/counter_updown_mod.sv | 71 +++++++
 1 files changed

// File: rtl/counter_updown_mod.sv
// Synchronous up/down modulo counter.
// Features: programmable inclusive limit, wrap or saturate at the
// boundaries, synchronous load, and a registered terminal-count pulse.
module counter_updown_mod #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0,
  parameter bit                SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_bound
);

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  // Boundary flag for the current direction, visible in the same cycle
  assign at_bound = (!dir && (q >= lim)) || (dir && (q == '0));

  // Next-state selection: load > enabled step > hold
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = load_val;
    end else if (en) begin
      if (!dir) begin
        if (q < lim) begin
          q_nxt = q + WIDTH'(1);
        end else begin
          // At or above the limit: this edge is a boundary event
          tc_nxt = 1'b1;
          if (q == lim) begin
            q_nxt = SATURATE ? q : '0;
          end else begin
            q_nxt = SATURATE ? lim : '0;
          end
        end
      end else begin
        if (q > lim) begin
          // Out of range from above: step back into range quietly
          q_nxt = lim;
        end else if (q == '0) begin
          tc_nxt = 1'b1;
          q_nxt  = SATURATE ? '0 : lim;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= RST_VAL;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

endmodule
